// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes,
// dump engine state encoding and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'b00,
        DUMP_READ = 2'b01,
        DUMP_SEND = 2'b10,
        DUMP_DONE = 2'b11
    } dump_state_e;

    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SIZE_BYTE: m = 4'b0001 << lsb;
            SIZE_HALF: m = lsb[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/byte_lane_ram_async.sv
// Word-organised RAM with per-byte write enables and two
// asynchronous read ports (CPU load path and dump engine).
module byte_lane_ram_async #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic [3:0]            i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    output logic [31:0]           o_rdata_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [31:0]           o_rdata_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                mem_q[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    assign o_rdata_a = mem_q[i_raddr_a];
    assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: byte/half/word stores, extended loads,
// alignment checking and a handshaked full-array dump engine.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH+1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_misaligned,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_valid,
    output logic                  o_dump_done,
    output logic                  o_busy
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_memory_ctrl: DATA_WIDTH must be 32");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]           dump_data_q, dump_data_d;

    logic [31:0] rd_cpu;
    logic [31:0] rd_dump;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic        busy;

    assign busy = (state_q != DUMP_IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = i_addr[0];
            SIZE_WORD: misaligned = (i_addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    // Narrow store data is replicated so the lane mask alone picks the target.
    always_comb begin
        wdata = i_data;
        case (i_size)
            SIZE_BYTE: wdata = {4{i_data[7:0]}};
            SIZE_HALF: wdata = {2{i_data[15:0]}};
            default:   wdata = i_data;
        endcase
        we = 4'b0000;
        if (i_write_enable && !misaligned && !busy) begin
            we = lane_mask(i_size, i_addr[1:0]);
        end
    end

    byte_lane_ram_async #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (we),
        .i_waddr  (i_addr[ADDR_WIDTH+1:2]),
        .i_wdata  (wdata),
        .i_raddr_a(i_addr[ADDR_WIDTH+1:2]),
        .o_rdata_a(rd_cpu),
        .i_raddr_b(cnt_q),
        .o_rdata_b(rd_dump)
    );

    always_comb begin
        lane_b    = rd_cpu[{i_addr[1:0], 3'b000} +: 8];
        lane_h    = rd_cpu[{i_addr[1], 4'b0000} +: 16];
        load_data = 32'h0;
        if (!misaligned) begin
            case (i_size)
                SIZE_BYTE: load_data = i_unsigned ? {24'h0, lane_b}
                                                  : {{24{lane_b[7]}}, lane_b};
                SIZE_HALF: load_data = i_unsigned ? {16'h0, lane_h}
                                                  : {{16{lane_h[15]}}, lane_h};
                SIZE_WORD: load_data = rd_cpu;
                default:   load_data = 32'h0;
            endcase
        end
    end

    assign o_data       = load_data;
    assign o_misaligned = misaligned;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dump_data_d = dump_data_q;
        case (state_q)
            DUMP_IDLE: begin
                if (i_dump_start) begin
                    state_d = DUMP_READ;
                end
            end
            DUMP_READ: begin
                dump_data_d = rd_dump;
                state_d     = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (i_dump_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = DUMP_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = DUMP_READ;
                    end
                end
            end
            DUMP_DONE: begin
                cnt_d   = '0;
                state_d = DUMP_IDLE;
            end
            default: state_d = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= DUMP_IDLE;
            cnt_q       <= '0;
            dump_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign o_dump_data  = dump_data_q;
    assign o_dump_valid = (state_q == DUMP_SEND);
    assign o_dump_done  = (state_q == DUMP_DONE);
    assign o_busy       = busy;

endmodule
